// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared bus macros, fetch-entry type and helpers for the instruction fetch slice
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus 31:0
`define ZeroWord 32'h0000_0000
`define CpuResetAddr 32'h0000_0000
`endif

package if_fetch_pkg;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction
endpackage

// File: rtl/if_skid_fifo.sv
// if_skid_fifo: 2-entry synchronous FIFO of {inst, pc} with push, pop, flush and occupancy count
module if_skid_fifo
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din_inst,
  input  logic [31:0] din_pc,
  output logic [31:0] dout_inst,
  output logic [31:0] dout_pc,
  output logic [1:0]  count
);
  fetch_entry_t mem [2];
  logic rd, wr;
  assign dout_inst = mem[rd].inst;
  assign dout_pc = mem[rd].pc;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= '{inst: din_inst, pc: din_pc};
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC and ROM request logic feeding a skid FIFO towards decode; redirects flush wrong-path fetches
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = `CpuResetAddr,
  parameter int          FIFO_DP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_en_i,
  input  logic [`InstAddrBus] jump_addr_i,
  output logic [`InstAddrBus] rom_addr_o,
  output logic                rom_cs_o,
  output logic                rom_we_o,
  output logic [3:0]          rom_wem_o,
  output logic [`InstBus]     rom_data_o,
  input  logic [`InstBus]     rom_data_i,
  output logic                inst_valid_o,
  output logic [`InstBus]     inst_o,
  output logic [`InstAddrBus] inst_addr_o,
  input  logic                id_ready_i
);
  logic [31:0] pc, pend_pc, head_inst, head_pc;
  logic [1:0] count;
  logic [2:0] occ;
  logic pend, pop, issue;
  assign inst_valid_o = !rst && count != 2'd0;
  assign pop = inst_valid_o && id_ready_i;
  // occupancy after this cycle if nothing new is issued; keeps a slot for every in-flight response
  assign occ = {1'b0, count} + {2'b0, pend} - {2'b0, pop};
  assign issue = !rst && (jump_en_i || occ < 3'(FIFO_DP));
  assign rom_addr_o = jump_en_i ? word_align(jump_addr_i) : pc;
  assign rom_cs_o = issue;
  assign rom_we_o = 1'b0;
  assign rom_wem_o = 4'b0000;
  assign rom_data_o = `ZeroWord;
  assign inst_o = inst_valid_o ? head_inst : `ZeroWord;
  assign inst_addr_o = inst_valid_o ? head_pc : `ZeroWord;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      pend <= 1'b0;
      pend_pc <= `ZeroWord;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_pc <= rom_addr_o;
        pc <= rom_addr_o + WORD_BYTES;
      end
    end
  end
  if_skid_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (jump_en_i),
    .push     (pend && !jump_en_i),
    .pop      (pop && !jump_en_i),
    .din_inst (rom_data_i),
    .din_pc   (pend_pc),
    .dout_inst(head_inst),
    .dout_pc  (head_pc),
    .count    (count)
  );
endmodule
